sync_trigger_ctrl: RTL

Receiving end of the synchronization-block stimulus interface: takes the asynchronous experiment signals (start condition, fast gate, RF phase, wire sensor), sequences the detonator firing pulse and the phase-aligned output trigger, and reports faults. It sits directly behind the front-panel input buffers. It is the DUT driven by the team's scenario benches.

---
 rtl/sync_trigger_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sync_trigger_ctrl.sv
// rtl/sync_trigger_ctrl.sv - detonator/trigger sequencer for the sync block; SYNC_PHASE_ALIGN_EN enables phase-aligned output trigger
module sync_trigger_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int GATE_DELAY   = 1000,
   parameter int FIRE_WIDTH   = 10,
   parameter int DEBOUNCE     = 200,
   parameter int WIRE_TIMEOUT = 1_000_000,
   parameter int TRIG_WIDTH   = 50,
   parameter int CNT_W        = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_condition,
   input  logic       fast_gate,
   input  logic       phase_signal,
   input  logic       wire_sensor,
   output logic       detonator_fire,
   output logic       output_trigger,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ARMED      = 3'd1,
      S_DELAY      = 3'd2,
      S_FIRE       = 3'd3,
      S_WAIT_WIRE  = 3'd4,
      S_WAIT_PHASE = 3'd5,
      S_TRIG       = 3'd6,
      S_FAULT      = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] GATE_LOAD  = CNT_W'(GATE_DELAY - 1);
   localparam logic [CNT_W-1:0] FIRE_LOAD  = CNT_W'(FIRE_WIDTH - 1);
   localparam logic [CNT_W-1:0] WIRE_LOAD  = CNT_W'(WIRE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TRIG_LOAD  = CNT_W'(TRIG_WIDTH - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);

   // bit 0 is the first synchronizer stage, bit 1 the metastability-safe output
   logic [1:0]       start_sync_q, start_sync_d;
   logic [1:0]       gate_sync_q, gate_sync_d;
   logic [1:0]       wire_sync_q, wire_sync_d;
   logic             start_prev_q, start_prev_d;
   logic             gate_prev_q, gate_prev_d;
   logic             start_rise, gate_rise, wire_hi;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic             fire_q, fire_d;
   logic             trig_q, trig_d;
   logic             busy_q, busy_d;
   logic             fault_q, fault_d;

   // CLK_HZ only documents the intended clock; phase_signal is consumed only when phase alignment is built
   logic             unused_cfg;

`ifdef SYNC_PHASE_ALIGN_EN
   logic [1:0]       phase_sync_q, phase_sync_d;
   logic             phase_prev_q, phase_prev_d;
   logic             phase_rise;

   assign unused_cfg = (CLK_HZ > 0);

   // phase reference synchronizer and edge register
   always_comb begin
      phase_sync_d = {phase_sync_q[0], phase_signal};
      phase_prev_d = phase_sync_q[1];
   end

   // phase synchronizer flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_sync_q <= '0;
         phase_prev_q <= 1'b0;
      end else begin
         phase_sync_q <= phase_sync_d;
         phase_prev_q <= phase_prev_d;
      end
   end

   assign phase_rise = phase_sync_q[1] & ~phase_prev_q;
`else
   assign unused_cfg = (CLK_HZ > 0) ^ phase_signal;
`endif

   // synchronizer shift and edge-register next values; the wire is level-qualified so it needs no edge register
   always_comb begin
      start_sync_d = {start_sync_q[0], start_condition};
      gate_sync_d  = {gate_sync_q[0], fast_gate};
      wire_sync_d  = {wire_sync_q[0], wire_sensor};
      start_prev_d = start_sync_q[1];
      gate_prev_d  = gate_sync_q[1];
   end

   // synchronizer and edge flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_sync_q <= '0;
         gate_sync_q  <= '0;
         wire_sync_q  <= '0;
         start_prev_q <= 1'b0;
         gate_prev_q  <= 1'b0;
      end else begin
         start_sync_q <= start_sync_d;
         gate_sync_q  <= gate_sync_d;
         wire_sync_q  <= wire_sync_d;
         start_prev_q <= start_prev_d;
         gate_prev_q  <= gate_prev_d;
      end
   end

   assign start_rise = start_sync_q[1] & ~start_prev_q;
   assign gate_rise  = gate_sync_q[1] & ~gate_prev_q;
   assign wire_hi    = wire_sync_q[1];

   // next state, shared down-counter, debounce counter and next-state output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
      deb_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (gate_rise) begin
               state_d = S_DELAY;
               cnt_d   = GATE_LOAD;
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) begin
               state_d = S_FIRE;
               cnt_d   = FIRE_LOAD;
            end
         end
         S_FIRE: begin
            if (cnt_q == '0) begin
               state_d = S_WAIT_WIRE;
               cnt_d   = WIRE_LOAD;
            end
         end
         S_WAIT_WIRE: begin
            if (wire_hi && deb_q != DEB_LAST) deb_d = deb_q + ONE;
            if (wire_hi && deb_q == DEB_LAST) begin
               // acceptance takes priority over a timeout in the same cycle
`ifdef SYNC_PHASE_ALIGN_EN
               state_d = S_WAIT_PHASE;
`else
               state_d = S_TRIG;
               cnt_d   = TRIG_LOAD;
`endif
            end else if (cnt_q == '0) begin
               state_d = S_FAULT;
            end
         end
         S_WAIT_PHASE: begin
`ifdef SYNC_PHASE_ALIGN_EN
            if (phase_rise) begin
               state_d = S_TRIG;
               cnt_d   = TRIG_LOAD;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_TRIG: begin
            if (cnt_q == '0) state_d = S_IDLE;
         end
         S_FAULT: begin
            if (start_rise) state_d = S_ARMED;
         end
         default: state_d = S_IDLE;
      endcase

      fire_d  = (state_d == S_FIRE);
      trig_d  = (state_d == S_TRIG);
      busy_d  = !(state_d == S_IDLE || state_d == S_FAULT);
      fault_d = (state_d == S_FAULT);
   end

   // FSM, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         deb_q   <= '0;
         fire_q  <= 1'b0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
         fire_q  <= fire_d;
         trig_q  <= trig_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   assign detonator_fire = fire_q;
   assign output_trigger = trig_q;
   assign busy           = busy_q;
   assign fault          = fault_q;
   assign state_o        = state_q;

endmodule
